// File: rtl/video_timing_gen_pkg.sv
// Shared defaults and helpers for the raster timing generator.
package video_timing_gen_pkg;

    // 640x480@60 raster at half horizontal rate (12.5875 MHz pixel clock)
    localparam int DEF_H_VISIBLE = 320;
    localparam int DEF_H_FP      = 8;
    localparam int DEF_H_SYNC    = 48;
    localparam int DEF_H_BP      = 24;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam bit DEF_HSYNC_POL = 1'b0;
    localparam bit DEF_VSYNC_POL = 1'b0;

    // 256x240 game field placement inside the raster
    localparam int DEF_GAME_W    = 256;
    localparam int DEF_GAME_H    = 240;
    localparam int DEF_H_OFFSET  = 32;
    localparam int DEF_V_OFFSET  = 0;
    localparam int DEF_V_SCALE   = 2;
    localparam int DEF_PREFETCH  = 2;

    localparam int GAME_COORD_W  = 8;

    // Line-repeat factor expressed as a right shift on the display line index
    function automatic int scale_shift(input int scale);
        if (scale == 4) return 2;
        if (scale == 2) return 1;
        return 0;
    endfunction

    function automatic bit scale_legal(input int scale);
        return (scale == 1) || (scale == 2) || (scale == 4);
    endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// One raster axis: wrapping position counter plus sync/active decode.
module video_timing_gen_axis
    import video_timing_gen_pkg::*;
#(
    parameter int VISIBLE = DEF_H_VISIBLE,
    parameter int FP      = DEF_H_FP,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BP      = DEF_H_BP,
    parameter int W       = $clog2(VISIBLE + FP + SYNC + BP)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         in_sync,
    output logic         active
);

    localparam int TOTAL = VISIBLE + FP + SYNC + BP;

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_FIRST = W'(VISIBLE + FP);
    localparam logic [W-1:0] SYNC_LAST  = W'(VISIBLE + FP + SYNC - 1);
    localparam logic [W-1:0] VIS_END    = W'(VISIBLE);

    // Position counter: advances when enabled, wraps at the end of the axis
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // Carry and region decode of the current count
    always_comb begin
        wrap    = en && (cnt == LAST);
        in_sync = (cnt >= SYNC_FIRST) && (cnt <= SYNC_LAST);
        active  = cnt < VIS_END;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: sync, blanking, game-field coordinates,
// prefetch coordinate and line/frame strobes, all registered.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = DEF_HSYNC_POL,
    parameter bit VSYNC_POL = DEF_VSYNC_POL,
    parameter int GAME_W    = DEF_GAME_W,
    parameter int GAME_H    = DEF_GAME_H,
    parameter int H_OFFSET  = DEF_H_OFFSET,
    parameter int V_OFFSET  = DEF_V_OFFSET,
    parameter int V_SCALE   = DEF_V_SCALE,
    parameter int PREFETCH  = DEF_PREFETCH
) (
    input  logic                    clk_12_5875,
    input  logic                    rst,
    input  logic                    blank_req,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    visible,
    output logic                    in_game,
    output logic [GAME_COORD_W-1:0] game_x,
    output logic [GAME_COORD_W-1:0] game_y,
    output logic                    fetch_valid,
    output logic [GAME_COORD_W-1:0] fetch_x,
    output logic                    line_start,
    output logic                    frame_start,
    output logic                    vblank
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int VS_SHIFT = scale_shift(V_SCALE);

    localparam logic [HW-1:0] H_OFF  = HW'(H_OFFSET);
    localparam logic [HW-1:0] H_WIN  = HW'(GAME_W);
    localparam logic [HW-1:0] H_LEAD = HW'(PREFETCH);
    localparam logic [VW-1:0] V_OFF  = VW'(V_OFFSET);
    localparam logic [VW-1:0] V_SPAN = VW'(GAME_H * V_SCALE);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);

    if (H_OFFSET + GAME_W > H_VISIBLE) begin : g_bad_h_window
        $error("game window exceeds visible width");
    end
    if (V_OFFSET + GAME_H * V_SCALE > V_VISIBLE) begin : g_bad_v_window
        $error("game window exceeds visible height");
    end
    if (GAME_W < 1 || GAME_W > 256 || GAME_H < 1 || GAME_H > 256) begin : g_bad_game_size
        $error("game field size out of range");
    end
    if (PREFETCH < 0 || PREFETCH > H_OFFSET) begin : g_bad_prefetch
        $error("PREFETCH must lie in 0..H_OFFSET");
    end
    if (!scale_legal(V_SCALE)) begin : g_bad_scale
        $error("V_SCALE must be 1, 2 or 4");
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap_unused;
    logic          h_sync_act;
    logic          v_sync_act;
    logic          h_active;
    logic          v_active;

    video_timing_gen_axis #(
        .VISIBLE (H_VISIBLE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP),
        .W       (HW)
    ) u_h_axis (
        .clk     (clk_12_5875),
        .rst     (rst),
        .en      (1'b1),
        .cnt     (h_cnt),
        .wrap    (h_wrap),
        .in_sync (h_sync_act),
        .active  (h_active)
    );

    video_timing_gen_axis #(
        .VISIBLE (V_VISIBLE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP),
        .W       (VW)
    ) u_v_axis (
        .clk     (clk_12_5875),
        .rst     (rst),
        .en      (h_wrap),
        .cnt     (v_cnt),
        .wrap    (v_wrap_unused),
        .in_sync (v_sync_act),
        .active  (v_active)
    );

    logic [HW-1:0]           h_rel;
    logic [HW-1:0]           f_rel;
    logic [VW-1:0]           v_rel;
    logic                    game_line;
    logic                    visible_d;
    logic                    in_game_d;
    logic                    fetch_valid_d;
    logic [GAME_COORD_W-1:0] game_x_d;
    logic [GAME_COORD_W-1:0] game_y_d;
    logic [GAME_COORD_W-1:0] fetch_x_d;

    // Decode of the current counters. Window tests use modular offsets:
    // positions before a window's start wrap to values >= its size, so a
    // single unsigned "< size" compare covers both window edges.
    always_comb begin
        h_rel         = h_cnt - H_OFF;
        f_rel         = h_cnt + H_LEAD - H_OFF;
        v_rel         = v_cnt - V_OFF;
        game_line     = v_rel < V_SPAN;
        visible_d     = h_active && v_active && !blank_req;
        in_game_d     = visible_d && game_line && (h_rel < H_WIN);
        fetch_valid_d = game_line && (f_rel < H_WIN);
        game_x_d      = in_game_d ? GAME_COORD_W'(h_rel) : '0;
        fetch_x_d     = fetch_valid_d ? GAME_COORD_W'(f_rel) : '0;
        game_y_d      = game_line ? GAME_COORD_W'(v_rel >> VS_SHIFT) : '0;
    end

    // Output register: one clock behind the counters, idle values on reset
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            visible     <= 1'b0;
            in_game     <= 1'b0;
            game_x      <= '0;
            game_y      <= '0;
            fetch_valid <= 1'b0;
            fetch_x     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
        end else begin
            hsync       <= h_sync_act ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= v_sync_act ? VSYNC_POL : ~VSYNC_POL;
            visible     <= visible_d;
            in_game     <= in_game_d;
            game_x      <= game_x_d;
            game_y      <= game_y_d;
            fetch_valid <= fetch_valid_d;
            fetch_x     <= fetch_x_d;
            line_start  <= game_line && (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == V_VIS);
            vblank      <= !v_active;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: three generator configurations share clock/reset/blank;
// expected outputs come from a position-from-cycle-count reference model.
module tb_video_timing_gen;

    typedef struct {
        int hv, hfp, hs, hbp;
        int vv, vfp, vs, vbp;
        bit hp, vp;
        int gw, gh, ho, vo, vsc, pf;
    } cfg_t;

    localparam int NINST    = 3;
    localparam int RUN_CYC  = 43000;
    localparam int RST_AT   = 100 * 400 + 150;   // default raster: v=100, h=150

    logic clk;
    logic rst;
    logic blank_req;

    logic       hsync_w  [NINST];
    logic       vsync_w  [NINST];
    logic       vis_w    [NINST];
    logic       ing_w    [NINST];
    logic [7:0] gx_w     [NINST];
    logic [7:0] gy_w     [NINST];
    logic       fv_w     [NINST];
    logic [7:0] fx_w     [NINST];
    logic       ls_w     [NINST];
    logic       fs_w     [NINST];
    logic       vb_w     [NINST];

    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          started  = 1'b0;

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    video_timing_gen u_dut0 (
        .clk_12_5875 (clk), .rst (rst), .blank_req (blank_req),
        .hsync (hsync_w[0]), .vsync (vsync_w[0]), .visible (vis_w[0]),
        .in_game (ing_w[0]), .game_x (gx_w[0]), .game_y (gy_w[0]),
        .fetch_valid (fv_w[0]), .fetch_x (fx_w[0]), .line_start (ls_w[0]),
        .frame_start (fs_w[0]), .vblank (vb_w[0])
    );

    video_timing_gen #(
        .H_VISIBLE (40), .H_FP (4), .H_SYNC (6), .H_BP (6),
        .V_VISIBLE (30), .V_FP (3), .V_SYNC (2), .V_BP (4),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1),
        .GAME_W (24), .GAME_H (20), .H_OFFSET (8), .V_OFFSET (5),
        .V_SCALE (1), .PREFETCH (3)
    ) u_dut1 (
        .clk_12_5875 (clk), .rst (rst), .blank_req (blank_req),
        .hsync (hsync_w[1]), .vsync (vsync_w[1]), .visible (vis_w[1]),
        .in_game (ing_w[1]), .game_x (gx_w[1]), .game_y (gy_w[1]),
        .fetch_valid (fv_w[1]), .fetch_x (fx_w[1]), .line_start (ls_w[1]),
        .frame_start (fs_w[1]), .vblank (vb_w[1])
    );

    video_timing_gen #(
        .H_VISIBLE (48), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_VISIBLE (32), .V_FP (2), .V_SYNC (3), .V_BP (3),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b1),
        .GAME_W (40), .GAME_H (8), .H_OFFSET (6), .V_OFFSET (0),
        .V_SCALE (4), .PREFETCH (6)
    ) u_dut2 (
        .clk_12_5875 (clk), .rst (rst), .blank_req (blank_req),
        .hsync (hsync_w[2]), .vsync (vsync_w[2]), .visible (vis_w[2]),
        .in_game (ing_w[2]), .game_x (gx_w[2]), .game_y (gy_w[2]),
        .fetch_valid (fv_w[2]), .fetch_x (fx_w[2]), .line_start (ls_w[2]),
        .frame_start (fs_w[2]), .vblank (vb_w[2])
    );

    function automatic cfg_t cfg_of(input int i);
        cfg_t c;
        case (i)
            1:       c = '{40, 4, 6, 6, 30, 3, 2, 4, 1'b1, 1'b1, 24, 20, 8, 5, 1, 3};
            2:       c = '{48, 2, 4, 3, 32, 2, 3, 3, 1'b0, 1'b1, 40, 8, 6, 0, 4, 6};
            default: c = '{320, 8, 48, 24, 480, 10, 2, 33, 1'b0, 1'b0, 256, 240, 32, 0, 2, 2};
        endcase
        return c;
    endfunction

    // Expected output word for the edge at which the raster has run t clocks
    // since reset (or the idle word when that edge samples reset).
    function automatic logic [31:0] model(input cfg_t c, input int t,
                                          input bit blank, input bit in_rst);
        int  ht, vt, h, v, fx, gx, gy, fxo;
        bit  hs, vs, vis, ig, gl, fv, ls, fs, vb;
        if (in_rst)
            return {~c.hp, ~c.vp, 30'd0};
        ht  = c.hv + c.hfp + c.hs + c.hbp;
        vt  = c.vv + c.vfp + c.vs + c.vbp;
        h   = t % ht;
        v   = (t / ht) % vt;
        hs  = (h >= c.hv + c.hfp && h < c.hv + c.hfp + c.hs) ? c.hp : ~c.hp;
        vs  = (v >= c.vv + c.vfp && v < c.vv + c.vfp + c.vs) ? c.vp : ~c.vp;
        gl  = (v >= c.vo) && (v < c.vo + c.gh * c.vsc);
        gy  = gl ? (v - c.vo) / c.vsc : 0;
        vis = (h < c.hv) && (v < c.vv) && !blank;
        ig  = vis && gl && (h >= c.ho) && (h < c.ho + c.gw);
        gx  = ig ? h - c.ho : 0;
        fx  = h + c.pf;
        fv  = gl && (fx >= c.ho) && (fx < c.ho + c.gw);
        fxo = fv ? fx - c.ho : 0;
        ls  = gl && (h == 0);
        fs  = (h == 0) && (v == c.vv);
        vb  = v >= c.vv;
        return {hs, vs, vis, ig, 8'(gx), 8'(gy), fv, 8'(fxo), ls, fs, vb};
    endfunction

    function automatic logic [31:0] actual(input int i);
        return {hsync_w[i], vsync_w[i], vis_w[i], ing_w[i], gx_w[i], gy_w[i],
                fv_w[i], fx_w[i], ls_w[i], fs_w[i], vb_w[i]};
    endfunction

    function automatic string fmt(input logic [31:0] w);
        return $sformatf("hs=%b vs=%b vis=%b ing=%b gx=%0d gy=%0d fv=%b fx=%0d ls=%b fs=%b vb=%b",
                         w[31], w[30], w[29], w[28], w[27:20], w[19:12],
                         w[11], w[10:3], w[2], w[1], w[0]);
    endfunction

    task automatic push_all(input int t, input bit blank, input bit in_rst);
        for (int i = 0; i < NINST; i++)
            sb.push_back(model(cfg_of(i), t, blank, in_rst));
    endtask

    // Stimulus: 3 reset cycles, long randomized-blank run, one mid-frame reset
    initial begin
        int t;
        rst       = 1'b1;
        blank_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst       = 1'b1;
            blank_req = 1'($urandom_range(0, 1));
            push_all(0, blank_req, 1'b1);
            started   = 1'b1;
        end
        t = 0;
        for (int k = 0; k < RUN_CYC; k++) begin
            @(negedge clk);
            rst       = (k == RST_AT);
            blank_req = ($urandom_range(0, 7) == 0);
            push_all(t, blank_req, rst);
            t = rst ? 0 : t + 1;
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor: every clock presents a new output word per instance
    initial begin
        logic [31:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                cyc++;
                if (sb.size() < NINST) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow cycle %0d: have %0d entries, need %0d",
                             cyc, sb.size(), NINST);
                end else begin
                    for (int i = 0; i < NINST; i++) begin
                        e = sb.pop_front();
                        a = actual(i);
                        n_checks++;
                        if (a !== e) begin
                            n_fail++;
                            $display("FAIL outputs inst%0d cycle %0d: got [%s] expected [%s]",
                                     i, cyc, fmt(a), fmt(e));
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator for the GPU, replacing the fixed 640x480 counter logic inside gpu_m. It produces hsync/vsync, blanking and game-window coordinates for a 256x240 game field scaled into the display raster. It also supplies a prefetch coordinate running PREFETCH cycles ahead so VRAM/pattern pipelines can deliver pixels on time, plus frame/line strobes for the CPU vblank interrupt. It sits between the pixel clock domain root and the GPU pixel pipeline.

Parameters:
H_VISIBLE, 320, visible pixel clocks per line (half-rate 640 mode)
H_FP, 8, horizontal front porch clocks
H_SYNC, 48, hsync width clocks
H_BP, 24, horizontal back porch clocks
V_VISIBLE, 480, visible lines
V_FP, 10, vertical front porch lines
V_SYNC, 2, vsync lines
V_BP, 33, vertical back porch lines
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
GAME_W, 256, game field width in pixel clocks (game_x max GAME_W-1, <=256)
GAME_H, 240, game field height in game lines (<=256)
H_OFFSET, 32, first h count inside game field
V_OFFSET, 0, first v count inside game field
V_SCALE, 2, display lines per game line (1, 2 or 4)
PREFETCH, 2, lead of fetch_x over game_x in clocks (0..H_OFFSET)

Ports:
clk_12_5875  in  1  pixel clock
rst  in  1  synchronous reset, active-high
blank_req  in  1  forces visible/in_game low (sync unaffected), sampled each cycle
hsync  out  1  horizontal sync at HSYNC_POL
vsync  out  1  vertical sync at VSYNC_POL
visible  out  1  active video region
in_game  out  1  current pixel inside game field
game_x  out  8  game column of current pixel
game_y  out  8  game row of current line
fetch_valid  out  1  fetch_x refers to a game pixel on this game line
fetch_x  out  8  game column PREFETCH clocks ahead
line_start  out  1  one-cycle pulse at h=0 of each game line
frame_start  out  1  one-cycle pulse at h=0, v=V_VISIBLE (vblank entry)
vblank  out  1  high for v in [V_VISIBLE, V_TOTAL-1]

Behaviour:
- H_TOTAL=H_VISIBLE+H_FP+H_SYNC+H_BP (400); V_TOTAL likewise (525). Counter widths $clog2(TOTAL).
- h increments each clock, wraps H_TOTAL-1 -> 0; v increments on the h wrap, wraps V_TOTAL-1 -> 0.
- All outputs registered: at each non-reset edge outputs <= decode(h,v) of the current counters, then counters advance. Output latency one clock after counter value.
- Reset edge (rst=1): h=0, v=0; hsync=~HSYNC_POL, vsync=~VSYNC_POL, all other outputs 0. First post-reset edge presents decode(0,0). Reset mid-frame abandons the frame immediately; no partial strobes.
- hsync active for h in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]; vsync active for v in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1].
- visible = h<H_VISIBLE & v<V_VISIBLE & ~blank_req.
- game line: v in [V_OFFSET, V_OFFSET+GAME_H*V_SCALE-1]; game_y=(v-V_OFFSET)/V_SCALE (shift), held 0 outside.
- in_game = visible & game line & h in [H_OFFSET, H_OFFSET+GAME_W-1]; game_x=h-H_OFFSET truncated to 8 bits when in_game, else 0.
- fetch_valid = game line & (h+PREFETCH) in game window; fetch_x=h+PREFETCH-H_OFFSET when valid else 0. Not gated by blank_req.
- line_start only on game lines (every display line, including repeats under V_SCALE).
- Illegal parameter combinations (window exceeding visible area, PREFETCH>H_OFFSET) are rejected at elaboration.

Decomposition:
- Timing defaults and derived totals as `defines in headers/parameters.vh alongside VRAM_ADDR_WIDTH.
- One sub-module natural: sync_axis_m (counter + wrap + sync/active decode for one axis), instanced for h and v with carry from h into v.

Test Plan:
- Hold rst 3 cycles -> hsync=vsync=1, all others 0; first edge after release shows visible=1, game_x=0, in_game=0.
- Run one line -> in_game rises at output of h=32 (game_x=0), last at h=287 (game_x=255); hsync low for exactly 48 clocks from h=328.
- Run two frames -> frame_start spacing exactly 210000 clocks; vsync low 2 lines (800 clocks); vblank 45 lines.
- Check v=0,1 -> game_y=0; v=2 -> 1; v=479 -> 239; line_start count per frame = 480.
- PREFETCH=2: fetch_valid first at h=30 with fetch_x=0, last at h=285 with fetch_x=255; blank_req=1 clears visible/in_game but not fetch_valid/hsync.
- Assert rst at v=100,h=150 -> next outputs match reset values; instance with HSYNC_POL=1,V_SCALE=1,GAME_H=240,V_OFFSET=120 -> hsync high-active, game_y=0 at v=120, 239 at v=359.
